// File: rtl/eq_pkg.sv
// Shared definitions for the equalizer output stage: FSM states, saturation
// mode selectors and a constant-evaluable clog2 used for port widths.
package eq_pkg;

    typedef enum logic {
        ACC  = 1'b0,
        HOLD = 1'b1
    } state_t;

    localparam int SAT_PARTIAL = 0;
    localparam int SAT_FINAL   = 1;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/sat_band_accum_if.sv
// Sample-in / frame-out bus of the band accumulator.
interface sat_band_accum_if #(
    parameter int Width = 16
);
    // Both channels transfer on a cycle where valid && ready is high at the
    // rising edge; a source holds valid and data stable until that happens.
    logic             in_valid;
    logic             in_ready;
    logic [Width-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [Width-1:0] out_data;
    logic             out_sat;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_data,
        input  out_sat
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_data,
        output out_sat
    );

endinterface

// File: rtl/sat_clip.sv
// Clamps a signed InW-bit value into the signed OutW-bit range and reports
// whether the clamp changed the value.
module sat_clip #(
    parameter int InW  = 17,
    parameter int OutW = 16
) (
    input  logic [InW-1:0]  din,
    output logic [OutW-1:0] dout,
    output logic            clip
);

    localparam int TopW = InW - OutW + 1;

    // The value fits only when every bit from the OutW sign position upward
    // is a copy of the true sign.
    logic [TopW-1:0] top;
    assign top = din[InW-1:OutW-1];

    always_comb begin
        clip = !((top == '0) || (top == '1));
        dout = din[OutW-1:0];
        if (clip) begin
            dout = din[InW-1] ? {1'b1, {(OutW-1){1'b0}}}
                              : {1'b0, {(OutW-1){1'b1}}};
        end
    end

endmodule

// File: rtl/sat_band_accum.sv
// Serial saturating accumulator: sums Bands signed samples per frame and
// offers the clamped frame sum downstream, counting clipped frames.
module sat_band_accum
    import eq_pkg::*;
#(
    parameter int Width    = 16,
    parameter int Bands    = 4,
    parameter int SatMode  = 0,
    parameter int CntWidth = 16
) (
    input  logic                      clk,
    input  logic                      reset,
    sat_band_accum_if.slave           bus,
    input  logic                      clear_count,
    output logic [clog2(Bands)-1:0]   band_idx,
    output logic [CntWidth-1:0]       clip_count,
    output state_t                    fsm_state
);

    localparam int IdxW   = clog2(Bands);
    localparam int GuardW = (SatMode == SAT_FINAL) ? IdxW : 0;
    localparam int AccW   = Width + GuardW;

    state_t            state_q;
    state_t            state_d;
    logic [IdxW-1:0]   band_idx_q;
    logic [AccW-1:0]   acc_q;
    logic [AccW-1:0]   next_acc;
    logic [Width-1:0]  out_data_q;
    logic              out_sat_q;
    logic [CntWidth-1:0] clip_count_q;
    logic [Width-1:0]  frame_data;
    logic              frame_sat;
    logic              in_ready_c;
    logic              out_valid_c;
    logic              beat;
    logic              first_band;
    logic              last_band;

    assign beat       = bus.in_valid && (state_q == ACC);
    assign first_band = (band_idx_q == '0);
    assign last_band  = (band_idx_q == IdxW'(Bands - 1));

    always_comb begin
        state_d     = state_q;
        in_ready_c  = 1'b0;
        out_valid_c = 1'b0;
        case (state_q)
            ACC: begin
                in_ready_c = 1'b1;
                if (bus.in_valid && last_band) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                out_valid_c = 1'b1;
                if (bus.out_ready) begin
                    state_d = ACC;
                end
            end
            default: state_d = ACC;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ACC;
        end else begin
            state_q <= state_d;
        end
    end

    if (SatMode == SAT_PARTIAL) begin : g_partial
        logic [Width:0]   raw_sum;
        logic [Width-1:0] clip_sum;
        logic             add_clip;
        logic             beat_clip;
        logic             clip_q;

        // One extra bit is enough to hold any two-operand sum before clamping.
        assign raw_sum = {acc_q[Width-1], acc_q} + {bus.in_data[Width-1], bus.in_data};

        sat_clip #(
            .InW  (Width + 1),
            .OutW (Width)
        ) u_clip (
            .din  (raw_sum),
            .dout (clip_sum),
            .clip (add_clip)
        );

        assign beat_clip  = first_band ? 1'b0 : add_clip;
        assign next_acc   = first_band ? bus.in_data : clip_sum;
        assign frame_data = next_acc;
        assign frame_sat  = clip_q | beat_clip;

        // Sticky per-frame record of any partial sum that clipped.
        always_ff @(posedge clk) begin
            if (reset) begin
                clip_q <= 1'b0;
            end else if (beat) begin
                clip_q <= last_band ? 1'b0 : (clip_q | beat_clip);
            end
        end
    end else begin : g_final
        logic [AccW-1:0] wide_in;
        logic [AccW-1:0] wide_sum;

        assign wide_in  = {{GuardW{bus.in_data[Width-1]}}, bus.in_data};
        assign wide_sum = acc_q + wide_in;
        assign next_acc = first_band ? wide_in : wide_sum;

        sat_clip #(
            .InW  (AccW),
            .OutW (Width)
        ) u_clip (
            .din  (next_acc),
            .dout (frame_data),
            .clip (frame_sat)
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            band_idx_q <= '0;
            acc_q      <= '0;
            out_data_q <= '0;
            out_sat_q  <= 1'b0;
        end else if (beat) begin
            if (last_band) begin
                band_idx_q <= '0;
                acc_q      <= '0;
                out_data_q <= frame_data;
                out_sat_q  <= frame_sat;
            end else begin
                band_idx_q <= band_idx_q + IdxW'(1);
                acc_q      <= next_acc;
            end
        end
    end

    // A clear wins over a clipped frame landing in the same cycle.
    always_ff @(posedge clk) begin
        if (reset || clear_count) begin
            clip_count_q <= '0;
        end else if (beat && last_band && frame_sat && (clip_count_q != '1)) begin
            clip_count_q <= clip_count_q + CntWidth'(1);
        end
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;
    assign band_idx      = band_idx_q;
    assign clip_count    = clip_count_q;
    assign fsm_state     = state_q;

endmodule

// File: tb/tb_sat_band_accum.sv
// Bench for sat_band_accum: three instances (partial mode, final mode, partial
// mode with a 2-bit counter) share one stimulus stream.
module tb_sat_band_accum;
    import eq_pkg::*;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear_count = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b0;
    logic [W-1:0]  in_data = '0;

    sat_band_accum_if #(.Width(W)) b0 ();
    sat_band_accum_if #(.Width(W)) b1 ();
    sat_band_accum_if #(.Width(W)) b2 ();

    assign b0.in_valid = in_valid;
    assign b0.in_data = in_data;
    assign b0.out_ready = out_ready;
    assign b1.in_valid = in_valid;
    assign b1.in_data = in_data;
    assign b1.out_ready = out_ready;
    assign b2.in_valid = in_valid;
    assign b2.in_data = in_data;
    assign b2.out_ready = out_ready;

    logic [1:0]  band_idx0, band_idx1, band_idx2;
    logic [15:0] clip_count0, clip_count1;
    logic [1:0]  clip_count2;
    state_t      st0, st1, st2;

    sat_band_accum #(.Width(W), .Bands(4), .SatMode(0), .CntWidth(16)) dut0 (
        .clk(clk), .reset(reset), .bus(b0), .clear_count(clear_count),
        .band_idx(band_idx0), .clip_count(clip_count0), .fsm_state(st0));
    sat_band_accum #(.Width(W), .Bands(4), .SatMode(1), .CntWidth(16)) dut1 (
        .clk(clk), .reset(reset), .bus(b1), .clear_count(clear_count),
        .band_idx(band_idx1), .clip_count(clip_count1), .fsm_state(st1));
    sat_band_accum #(.Width(W), .Bands(4), .SatMode(0), .CntWidth(2)) dut2 (
        .clk(clk), .reset(reset), .bus(b2), .clear_count(clear_count),
        .band_idx(band_idx2), .clip_count(clip_count2), .fsm_state(st2));

    // Clock and watchdog
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    // Scoreboard: {sat, data} per frame for each saturation mode
    logic [W:0] exp_q0[$];
    logic [W:0] exp_q1[$];
    int chk_cnt = 0;
    int pass_cnt = 0;
    int cnt0 = 0, cnt1 = 0, cnt2 = 0;

    typedef struct {
        logic [3:0][W-1:0] f;
        logic [W:0]        e0;
        logic [W:0]        e1;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic fail_now(input string name);
        chk_cnt++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0][W-1:0] frame4(input logic [W-1:0] a, input logic [W-1:0] b,
                                                  input logic [W-1:0] c, input logic [W-1:0] d);
        logic [3:0][W-1:0] r;
        r[0] = a;
        r[1] = b;
        r[2] = c;
        r[3] = d;
        return r;
    endfunction

    // Reference: clamp after every addition
    function automatic logic [W:0] model_partial(input logic [3:0][W-1:0] f);
        int acc;
        logic s;
        acc = 0;
        s = 1'b0;
        for (int i = 0; i < 4; i++) begin
            acc += int'($signed(f[i]));
            if (acc > 32767) begin acc = 32767; s = 1'b1; end
            else if (acc < -32768) begin acc = -32768; s = 1'b1; end
        end
        return {s, acc[15:0]};
    endfunction

    // Reference: exact sum, clamp once
    function automatic logic [W:0] model_final(input logic [3:0][W-1:0] f);
        int acc;
        logic s;
        acc = 0;
        s = 1'b0;
        for (int i = 0; i < 4; i++) acc += int'($signed(f[i]));
        if (acc > 32767) begin acc = 32767; s = 1'b1; end
        else if (acc < -32768) begin acc = -32768; s = 1'b1; end
        return {s, acc[15:0]};
    endfunction

    function automatic logic [W-1:0] rand_sample();
        logic [W-1:0] v;
        v = W'($urandom);
        case ($urandom_range(0, 3))
            0: return v;
            1: return 16'h7F00 | {8'h00, v[7:0]};
            2: return 16'h8000 | {8'h00, v[7:0]};
            default: return {{7{v[8]}}, v[8:0]};
        endcase
    endfunction

    // Driver tasks
    task automatic pulse_reset();
        reset = 1'b1;
        step();
        reset = 1'b0;
        cnt0 = 0;
        cnt1 = 0;
        cnt2 = 0;
    endtask

    task automatic send_beat(input logic [W-1:0] d);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_data = d;
        while (!b0.in_ready && n < 20) begin
            step();
            n++;
        end
        check("in_ready wait", {31'b0, b0.in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [3:0][W-1:0] f, input logic [W:0] e0,
                              input logic [W:0] e1, input bit clr);
        exp_q0.push_back(e0);
        exp_q1.push_back(e1);
        for (int i = 0; i < 4; i++) begin
            check("band_idx seq", {30'b0, band_idx0}, i);
            if (clr && i == 3) clear_count = 1'b1;
            send_beat(f[i]);
            clear_count = 1'b0;
        end
        if (clr) begin
            cnt0 = 0;
            cnt1 = 0;
            cnt2 = 0;
        end else begin
            if (e0[W]) begin
                if (cnt0 < 65535) cnt0++;
                if (cnt2 < 3) cnt2++;
            end
            if (e1[W] && cnt1 < 65535) cnt1++;
        end
    endtask

    task automatic receive_frame(input int stall);
        logic [W:0] e0, e1;
        int n;
        n = 0;
        while (!b0.out_valid && n < 20) begin
            step();
            n++;
        end
        if (exp_q0.size() == 0 || exp_q1.size() == 0) begin
            fail_now("scoreboard underflow");
            return;
        end
        e0 = exp_q0.pop_front();
        e1 = exp_q1.pop_front();
        check("out_valid", {31'b0, b0.out_valid}, 32'd1);
        check("clip_count m0", {16'b0, clip_count0}, cnt0);
        check("clip_count m1", {16'b0, clip_count1}, cnt1);
        check("clip_count c2", {30'b0, clip_count2}, cnt2);
        for (int s = 0; s <= stall; s++) begin
            check("m0 out_data", {16'b0, b0.out_data}, {16'b0, e0[W-1:0]});
            check("m0 out_sat", {31'b0, b0.out_sat}, {31'b0, e0[W]});
            check("m1 out_data", {16'b0, b1.out_data}, {16'b0, e1[W-1:0]});
            check("m1 out_sat", {31'b0, b1.out_sat}, {31'b0, e1[W]});
            check("c2 out_data", {16'b0, b2.out_data}, {16'b0, e0[W-1:0]});
            check("in_ready in HOLD", {31'b0, b0.in_ready}, 32'd0);
            check("band_idx in HOLD", {30'b0, band_idx0}, 32'd0);
            if (s < stall) begin
                in_valid = 1'b1;
                in_data = W'($urandom);
                step();
                check("out_valid stall", {31'b0, b0.out_valid}, 32'd1);
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("in_ready after accept", {31'b0, b0.in_ready}, 32'd1);
        check("m1 in_ready after accept", {31'b0, b1.in_ready}, 32'd1);
    endtask

    initial begin
        logic [3:0][W-1:0] f;

        vecs[0] = '{frame4(16'h7000, 16'h7000, 16'h9000, 16'h9000), {1'b1, 16'h9FFF}, {1'b0, 16'h0000}};
        vecs[1] = '{frame4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF), {1'b1, 16'h7FFF}, {1'b1, 16'h7FFF}};
        vecs[2] = '{frame4(16'h8000, 16'h8000, 16'h8000, 16'h8000), {1'b1, 16'h8000}, {1'b1, 16'h8000}};
        vecs[3] = '{frame4(16'h0001, 16'h0002, 16'h0003, 16'h0004), {1'b0, 16'h000A}, {1'b0, 16'h000A}};
        vecs[4] = '{frame4(16'h4000, 16'h4000, 16'hC000, 16'h0001), {1'b1, 16'h4000}, {1'b0, 16'h4001}};
        vecs[5] = '{frame4(16'hFFFF, 16'h0001, 16'h8000, 16'h7FFF), {1'b0, 16'hFFFF}, {1'b0, 16'hFFFF}};
        vecs[6] = '{frame4(16'h8000, 16'hFFFF, 16'h7FFF, 16'h0000), {1'b1, 16'hFFFF}, {1'b0, 16'hFFFE}};

        // Reset values
        step();
        step();
        step();
        check("reset in_ready", {31'b0, b0.in_ready}, 32'd1);
        check("reset out_valid", {31'b0, b0.out_valid}, 32'd0);
        check("reset out_data", {16'b0, b0.out_data}, 32'd0);
        check("reset out_sat", {31'b0, b0.out_sat}, 32'd0);
        check("reset band_idx", {30'b0, band_idx0}, 32'd0);
        check("reset clip_count", {16'b0, clip_count0}, 32'd0);
        check("reset state", {31'b0, st0}, {31'b0, ACC});
        check("reset m1 out_data", {16'b0, b1.out_data}, 32'd0);
        check("reset m1 out_valid", {31'b0, b1.out_valid}, 32'd0);
        reset = 1'b0;
        step();

        // Table vectors
        for (int v = 0; v < 7; v++) begin
            send_frame(vecs[v].f, vecs[v].e0, vecs[v].e1, 1'b0);
            receive_frame(0);
        end

        // Clip counter: clear, count, clear on HOLD entry, saturate
        clear_count = 1'b1;
        step();
        clear_count = 1'b0;
        cnt0 = 0;
        cnt1 = 0;
        cnt2 = 0;
        check("clear clip_count", {16'b0, clip_count0}, 32'd0);
        f = frame4(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        for (int k = 0; k < 3; k++) begin
            send_frame(f, {1'b1, 16'h7FFF}, {1'b1, 16'h7FFF}, 1'b0);
            receive_frame(0);
        end
        check("three clips", {16'b0, clip_count0}, 32'd3);
        send_frame(f, {1'b1, 16'h7FFF}, {1'b1, 16'h7FFF}, 1'b1);
        receive_frame(0);
        check("clear beats increment", {16'b0, clip_count0}, 32'd0);
        check("clear beats increment c2", {30'b0, clip_count2}, 32'd0);
        for (int k = 0; k < 5; k++) begin
            send_frame(f, {1'b1, 16'h7FFF}, {1'b1, 16'h7FFF}, 1'b0);
            receive_frame(0);
        end
        check("five clips", {16'b0, clip_count0}, 32'd5);
        check("2-bit counter saturates", {30'b0, clip_count2}, 32'd3);

        // Backpressure
        send_frame(frame4(16'd1, 16'd2, 16'd3, 16'd4), {1'b0, 16'd10}, {1'b0, 16'd10}, 1'b0);
        check("state HOLD", {31'b0, st0}, {31'b0, HOLD});
        receive_frame(5);

        // Reset mid-frame
        send_beat(16'h0100);
        send_beat(16'h0100);
        check("band_idx mid-frame", {30'b0, band_idx0}, 32'd2);
        pulse_reset();
        check("band_idx after reset", {30'b0, band_idx0}, 32'd0);
        check("out_valid after reset", {31'b0, b0.out_valid}, 32'd0);
        check("clip_count after reset", {16'b0, clip_count0}, 32'd0);
        send_frame(frame4(16'd5, 16'd5, 16'd5, 16'd5), {1'b0, 16'd20}, {1'b0, 16'd20}, 1'b0);
        receive_frame(0);

        // Reset during HOLD drops the pending result
        for (int i = 0; i < 4; i++) send_beat(16'h0007);
        check("HOLD before reset", {31'b0, b0.out_valid}, 32'd1);
        pulse_reset();
        check("HOLD dropped", {31'b0, b0.out_valid}, 32'd0);
        check("HOLD dropped data", {16'b0, b0.out_data}, 32'd0);
        check("HOLD dropped in_ready", {31'b0, b0.in_ready}, 32'd1);

        // Randomized frames against the reference model
        for (int k = 0; k < 24; k++) begin
            for (int i = 0; i < 4; i++) f[i] = rand_sample();
            send_frame(f, model_partial(f), model_final(f), 1'b0);
            receive_frame($urandom_range(0, 3));
        end

        if (exp_q0.size() != 0 || exp_q1.size() != 0) fail_now("scoreboard leftover");

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
